audio_stream_bridge: RTL

AUDIO_STREAM_BRIDGE -- requirements
Module: audio_stream_bridge

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_frame_fifo.sv | 59 +++++
 rtl/audio_stream_bridge.sv | 100 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream bridge.
// The attenuation width is fixed here so every user agrees on the port size.
package audio_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;
    localparam int          ATTEN_W      = 4;

endpackage

// File: rtl/audio_frame_fifo.sv
// Frame FIFO with a combinational head; push and pop may coincide.
// Occupancy is kept as an explicit counter so full and empty are unambiguous.
module audio_frame_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_stream_bridge.sv
// Codec-to-codec audio bridge with priming FIFO, swap/atten/mute and underrun count.
// Attenuation shifter is built only when AUDIO_STREAM_BRIDGE_ATTEN_EN is defined.
module audio_stream_bridge
    import audio_pkg::*;
#(
    parameter  int DATA_W    = 24,
    parameter  int NCH       = 2,
    parameter  int DEPTH     = 16,
    parameter  int PRIME_LVL = DEPTH / 2,
    localparam int FW        = NCH * DATA_W,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               read_ready,
    input  logic [FW-1:0]      readdata,
    output logic               read,
    input  logic               write_ready,
    output logic               write,
    output logic [FW-1:0]      writedata,
    input  logic               mute,
    input  logic               swap,
    input  logic [ATTEN_W-1:0] atten,
    output logic [LW-1:0]      level,
    output logic               running,
    output logic [15:0]        underrun_cnt
);

    state_t            state;
    logic              full;
    logic              empty;
    logic [FW-1:0]     head;
    logic [FW-1:0]     frame_out;
    logic [DATA_W-1:0] samp;

    // Handshakes are held off during reset so no pulse leaks out.
    assign read    = reset_n && read_ready && !full;
    assign write   = reset_n && (state == RUN) && write_ready && !empty;
    assign running = (state == RUN);

    audio_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .push      (read),
        .push_data (readdata),
        .pop       (write),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state        <= FILL;
            underrun_cnt <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (level >= LW'(PRIME_LVL)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (write_ready && empty) begin
                        state <= FILL;
                        if (underrun_cnt != UNDERRUN_MAX) begin
                            underrun_cnt <= underrun_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifndef AUDIO_STREAM_BRIDGE_ATTEN_EN
    logic unused_atten;
    assign unused_atten = ^atten;
`endif

    // Swap first, then attenuate, then mute, channel by channel.
    always_comb begin
        frame_out = '0;
        samp      = '0;
        for (int k = 0; k < NCH; k++) begin
            samp = swap ? head[(NCH-1-k)*DATA_W +: DATA_W]
                        : head[k*DATA_W +: DATA_W];
`ifdef AUDIO_STREAM_BRIDGE_ATTEN_EN
            samp = $signed(samp) >>> atten;
`endif
            frame_out[k*DATA_W +: DATA_W] = mute ? '0 : samp;
        end
    end

    assign writedata = write ? frame_out : '0;

endmodule
